frac_ratio_meter: RTL

- Measures the clock ratio of a divided clock, such as the output of the fractional/integer dividers, against the source clock CLK_in.
- Counts CLK_in cycles over WINDOW rising edges of SIG_in and reports the total plus the min/max single period.
- It is the checking end of the divider pair: it recovers the DIV_IN/DIV_OUT ratio for self-test and calibration.

---
 rtl/frac_div_pkg.sv | 27 ++
 rtl/sig_edge_sync.sv | 32 +++
 rtl/frac_ratio_meter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/frac_div_pkg.sv
// Shared definitions for the fractional-divider measurement blocks.
// Contents: FSM state encoding, parameter defaults, ceil-log2 helper.
// No ports.
package frac_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WINDOW      = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 4096;

  // Ceiling log2: bits needed to hold values 0..value-1.
  function automatic int int_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sig_edge_sync.sv
// Brings an asynchronous clock-under-test into CLK_in and flags its rising edges.
// Ports: CLK_in/RST (async active-low) clock and reset, D raw input,
//        EDGE one-cycle pulse per rising edge of D (3 flops from pin to pulse).
module sig_edge_sync
  import frac_div_pkg::*;
(
  input  logic CLK_in,
  input  logic RST,
  input  logic D,
  output logic EDGE
);

  logic sync_q1;
  logic sync_q2;
  logic sync_q3;

  // q1/q2 form the metastability synchronizer; q3 is the delayed copy for edge detect.
  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
    end else begin
      sync_q1 <= D;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  assign EDGE = sync_q2 & ~sync_q3;

endmodule

// File: rtl/frac_ratio_meter.sv
// Measures CLK_in cycles over WINDOW periods of SIG_in (total, min and max period).
// Ports: CLK_in/RST clock and async active-low reset; START begins a run; SIG_in clock under test;
//        BUSY run active; VALID one-cycle result strobe; TOTAL/PMIN/PMAX results; TIMEOUT_ERR abort flag;
//        SPREAD/FRAC_ERR jitter results, live only when FRAC_RATIO_METER_JITTER_EN is defined (else 0).
module frac_ratio_meter
  import frac_div_pkg::*;
#(
  parameter int WINDOW      = DEF_WINDOW,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             CLK_in,
  input  logic             RST,
  input  logic             START,
  input  logic             SIG_in,
  output logic             BUSY,
  output logic             VALID,
  output logic [CNT_W-1:0] TOTAL,
  output logic [CNT_W-1:0] PMIN,
  output logic [CNT_W-1:0] PMAX,
  output logic             TIMEOUT_ERR,
  output logic [CNT_W-1:0] SPREAD,
  output logic             FRAC_ERR
);

  localparam int EC_W  = int_log2(WINDOW + 1);
  localparam int TMR_W = (int_log2(TIMEOUT_CYC) < 1) ? 1 : int_log2(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic             edge_det;
  logic [CNT_W-1:0] pcnt_q, total_q, min_q, max_q;
  logic [EC_W-1:0]  ecnt_q;
  logic [TMR_W-1:0] timer_q;

  logic             timer_exp, last_edge, finish_ok, finish_abort;
  logic [CNT_W:0]   sum_full;
  logic [CNT_W-1:0] new_total, new_min, new_max;

  sig_edge_sync u_sync (
    .CLK_in (CLK_in),
    .RST    (RST),
    .D      (SIG_in),
    .EDGE   (edge_det)
  );

  // Values the internal registers take if the current cycle closes a period.
  assign sum_full  = {1'b0, total_q} + {1'b0, pcnt_q};
  assign new_total = sum_full[CNT_W] ? '1 : sum_full[CNT_W-1:0];
  assign new_min   = (pcnt_q < min_q) ? pcnt_q : min_q;
  assign new_max   = (pcnt_q > max_q) ? pcnt_q : max_q;
  assign timer_exp = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
  assign last_edge = (ecnt_q == EC_W'(WINDOW - 1));

  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    finish_ok    = 1'b0;
    finish_abort = 1'b0;
    case (state_q)
      IDLE: if (START) state_d = ARM;
      ARM: begin
        if (edge_det) state_d = MEAS;
        else if (timer_exp) begin
          state_d      = DONE;
          finish_abort = 1'b1;
        end
      end
      MEAS: begin
        if (edge_det) begin
          if (last_edge) begin
            state_d   = DONE;
            finish_ok = 1'b1;
          end
        end else if (timer_exp) begin
          state_d      = DONE;
          finish_abort = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign BUSY  = (state_q != IDLE);
  assign VALID = (state_q == DONE);

  // Measurement datapath.
  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      pcnt_q  <= '0;
      total_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
      ecnt_q  <= '0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            pcnt_q  <= '0;
            total_q <= '0;
            min_q   <= '1;
            max_q   <= '0;
            ecnt_q  <= '0;
            timer_q <= '0;
          end
        end
        ARM: begin
          if (edge_det) begin
            pcnt_q  <= CNT_W'(1);
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        MEAS: begin
          if (edge_det) begin
            total_q <= new_total;
            min_q   <= new_min;
            max_q   <= new_max;
            ecnt_q  <= ecnt_q + EC_W'(1);
            pcnt_q  <= CNT_W'(1);
            timer_q <= '0;
          end else begin
            pcnt_q  <= (pcnt_q == '1) ? pcnt_q : pcnt_q + CNT_W'(1);
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Results load on the edge entering DONE so they are visible with VALID.
  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      TOTAL       <= '0;
      PMIN        <= '0;
      PMAX        <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else if (finish_ok) begin
      TOTAL       <= new_total;
      PMIN        <= new_min;
      PMAX        <= new_max;
      TIMEOUT_ERR <= 1'b0;
    end else if (finish_abort) begin
      TOTAL       <= '0;
      PMIN        <= '0;
      PMAX        <= '0;
      TIMEOUT_ERR <= 1'b1;
    end
  end

`ifdef FRAC_RATIO_METER_JITTER_EN
  logic [CNT_W-1:0] spread_d;
  assign spread_d = new_max - new_min;

  // A healthy fractional divider only produces N and N+1, so spread above 1 is an error.
  always_ff @(posedge CLK_in or negedge RST) begin
    if (!RST) begin
      SPREAD   <= '0;
      FRAC_ERR <= 1'b0;
    end else if (finish_ok) begin
      SPREAD   <= spread_d;
      FRAC_ERR <= (spread_d > CNT_W'(1));
    end else if (finish_abort) begin
      SPREAD   <= '0;
      FRAC_ERR <= 1'b0;
    end
  end
`else
  assign SPREAD   = '0;
  assign FRAC_ERR = 1'b0;
`endif

endmodule
